cache_line_refill_unit: RTL
===========================

Name: cache_line_refill_unit

Overview:
- Miss-side engine of the set-associative cache. Sits between the tag store (`memory_of_tags`), the line data array and the backing main memory.
- On a front-end miss it optionally writes back the evicted (FIFO-victim) line, then refills the selected channel word by word from main memory.
- Finally it commits the new tag by pulsing `rewrite_tag` to the tag store, then signals completion.

Parameters:
- TAG_SIZE, 5, tag width; matches the tag store.
- INDEX_SIZE, 8, set index width; 256 sets.
- CHANNEL_SIZE, 2, channel (way) select width; 4 ways.
- WORD_SIZE, 2, word-in-line index width; WORDS_PER_LINE = 2**WORD_SIZE = 4.
- DATA_WIDTH, 16, data word width.
- ADDR_SIZE, TAG_SIZE+INDEX_SIZE+WORD_SIZE, main-memory word address width.

Ports:
- clk  in  1  clock.
- not_reset  in  1  asynchronous, active-low reset.
- miss_req  in  1  front-end miss request; sampled only in IDLE.
- miss_tag  in  TAG_SIZE  tag of the missing address.
- miss_index  in  INDEX_SIZE  set of the missing address.
- need_use_fifo  in  1  from tag store: set full, victim must be replaced.
- fifo_channel  in  CHANNEL_SIZE  from tag store: channel to be filled.
- fifo_tag_for_flush  in  TAG_SIZE  from tag store: tag of the victim.
- victim_dirty  in  1  dirty flag of the victim line.
- busy  out  1  high from the accept cycle through the done cycle.
- done  out  1  one-cycle completion pulse.
- rewrite_tag  out  1  one-cycle tag-commit pulse to the tag store.
- line_rd_en  out  1  data-array read strobe.
- line_rd_data  in  DATA_WIDTH  data-array read data, valid 1 cycle after line_rd_en.
- line_wr_en  out  1  data-array write strobe.
- line_channel  out  CHANNEL_SIZE  data-array channel for both reads and writes.
- line_word  out  WORD_SIZE  data-array word index.
- line_wr_data  out  DATA_WIDTH  data-array write data.
- mem_req  out  1  main-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_SIZE  main-memory address.
- mem_wdata  out  DATA_WIDTH  main-memory write data.
- mem_ack  in  1  main-memory transfer complete.
- mem_rdata  in  DATA_WIDTH  main-memory read data, valid with mem_ack.

Behaviour:
- Reset: async, active-low. State → IDLE; all outputs 0; word counter 0; latches 0.
- Reset mid-operation aborts immediately: no rewrite_tag, no done, mem_req drops.
- States: IDLE, FLUSH_RD, FLUSH_WR, FILL_RD, FILL_WR, COMMIT, DONE.
- IDLE, on miss_req=1:
  - latch miss_tag, miss_index, fifo_channel, fifo_tag_for_flush;
  - latch flush_needed = need_use_fifo & victim_dirty;
  - clear word counter; set busy;
  - next state = FLUSH_RD if flush_needed, else FILL_RD.
- miss_req while busy: ignored. The front end holds miss_tag/miss_index stable until done, because the tag store uses them live during COMMIT.
- FLUSH_RD (1 cycle):
  - line_rd_en=1, line_channel=latched channel, line_word=counter;
  - next state FLUSH_WR, capturing line_rd_data into the write-data register on entry.
- FLUSH_WR:
  - mem_req=1, mem_we=1, mem_addr={victim_tag, index, counter}, mem_wdata=captured word;
  - req/addr/we/wdata held stable until mem_ack=1.
  - On ack: mem_req=0 the next cycle; counter+1; next state FLUSH_RD, or after the last word: counter wraps to 0, next state FILL_RD.
- FILL_RD:
  - mem_req=1, mem_we=0, mem_addr={miss_tag, index, counter}, held until mem_ack.
  - On ack: capture mem_rdata; next state FILL_WR.
- FILL_WR (1 cycle):
  - line_wr_en=1, line_channel, line_word=counter, line_wr_data=captured word;
  - counter+1; next state FILL_RD, or after the last word: next state COMMIT.
- mem_req is low for at least 1 cycle between consecutive transfers. An ack arriving with mem_req=0 is ignored.
- COMMIT (1 cycle): rewrite_tag=1; the tag store writes the tag into fifo_channel and advances its FIFO pointer.
- DONE (1 cycle): done=1; busy drops the following cycle; next state IDLE. A new miss_req is accepted no earlier than the cycle after done.
- Clean miss (flush_needed=0): zero memory writes and exactly WORDS_PER_LINE reads.
- Dirty full set: WORDS_PER_LINE writes in word order 0..N-1, followed by WORDS_PER_LINE reads.
- Counter arithmetic: WORD_SIZE-bit, wraps modulo WORDS_PER_LINE. The last-word test is counter == all-ones.

Decomposition:
- Shared package `cache_pkg`:
  - state encoding localparams;
  - WORD_SIZE, WORDS_PER_LINE, ADDR_SIZE derivation;
  - address-compose function {tag, index, word}.
- Optional sub-module `cache_mem_port`: holds req/we/addr/wdata until ack, and enforces the 1-cycle idle gap. The FSM and counter stay in the top.

Test Plan:
- Clean miss: tag=5'h03, index=8'h10, need_use_fifo=0, memory acks 2 cycles after req → 4 reads at addr {03,10,0..3}; 4 line writes to fifo_channel; rewrite_tag one cycle, done the next; no mem_we=1.
- Dirty eviction: need_use_fifo=1, victim_dirty=1, victim tag 5'h1F, channel 2 → 4 writes at {1F,idx,0..3} carrying line_rd_data, then 4 reads at {new tag,idx,0..3}; line_channel=2 throughout.
- Full but clean victim: need_use_fifo=1, victim_dirty=0 → no write-back, fill only.
- Wait states: mem_ack delayed 0..7 random cycles → mem_req/addr/wdata stable until ack; req low ≥1 cycle between transfers; spurious ack while idle ignored.
- Reset mid-fill: deassert not_reset during the 3rd FILL_RD → outputs 0 immediately; no rewrite_tag/done; a fresh miss afterwards completes normally.
- Back-to-back misses with the tag store connected: 5 misses to one index (4 ways) → the 5th evicts channel 0; tag store hit on the new tag afterwards; miss_req during busy ignored.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry of the set-associative cache miss path.
// Holds default field widths, the refill FSM state encoding and the address layout.
package cache_pkg;

    localparam int CL_TAG_SIZE       = 5;
    localparam int CL_INDEX_SIZE     = 8;
    localparam int CL_CHANNEL_SIZE   = 2;
    localparam int CL_WORD_SIZE      = 2;
    localparam int CL_DATA_WIDTH     = 16;
    localparam int CL_WORDS_PER_LINE = 2 ** CL_WORD_SIZE;
    localparam int CL_ADDR_SIZE      = CL_TAG_SIZE + CL_INDEX_SIZE + CL_WORD_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH_RD = 3'd1,
        ST_FLUSH_WR = 3'd2,
        ST_FILL_RD  = 3'd3,
        ST_FILL_WR  = 3'd4,
        ST_COMMIT   = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Main-memory word address: tag in the MSBs, then set index, then word-in-line.
    function automatic logic [CL_ADDR_SIZE-1:0] compose_addr(
        input logic [CL_TAG_SIZE-1:0]   tag,
        input logic [CL_INDEX_SIZE-1:0] index,
        input logic [CL_WORD_SIZE-1:0]  word
    );
        return {tag, index, word};
    endfunction

endpackage

// File: rtl/cache_mem_port.sv
// Main-memory handshake: presents a transfer while the refill FSM asks for one,
// holds it until ack and forces one idle cycle after every completed transfer.
module cache_mem_port #(
    parameter int ADDR_SIZE  = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  not_reset,
    input  logic                  xfer_valid_i,
    input  logic                  xfer_we_i,
    input  logic [ADDR_SIZE-1:0]  xfer_addr_i,
    input  logic [DATA_WIDTH-1:0] xfer_wdata_i,
    output logic                  xfer_done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_SIZE-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i
);

    logic gap_q;

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= xfer_done_o;
        end
    end

    // Request is decoded from FSM state, so an async reset drops it at once.
    assign mem_req_o   = xfer_valid_i & ~gap_q;
    assign xfer_done_o = mem_req_o & mem_ack_i;
    assign mem_we_o    = mem_req_o & xfer_we_i;
    assign mem_addr_o  = mem_req_o ? xfer_addr_i : '0;
    assign mem_wdata_o = (mem_req_o & xfer_we_i) ? xfer_wdata_i : '0;

endmodule

// File: rtl/cache_line_refill_unit.sv
// Cache miss engine: optional write-back of the FIFO victim line, word-by-word refill
// from main memory, then a one-cycle tag commit and a one-cycle completion pulse.
module cache_line_refill_unit #(
    parameter int TAG_SIZE     = cache_pkg::CL_TAG_SIZE,
    parameter int INDEX_SIZE   = cache_pkg::CL_INDEX_SIZE,
    parameter int CHANNEL_SIZE = cache_pkg::CL_CHANNEL_SIZE,
    parameter int WORD_SIZE    = cache_pkg::CL_WORD_SIZE,
    parameter int DATA_WIDTH   = cache_pkg::CL_DATA_WIDTH,
    parameter int ADDR_SIZE    = TAG_SIZE + INDEX_SIZE + WORD_SIZE
) (
    input  logic                    clk,
    input  logic                    not_reset,
    input  logic                    miss_req,
    input  logic [TAG_SIZE-1:0]     miss_tag,
    input  logic [INDEX_SIZE-1:0]   miss_index,
    input  logic                    need_use_fifo,
    input  logic [CHANNEL_SIZE-1:0] fifo_channel,
    input  logic [TAG_SIZE-1:0]     fifo_tag_for_flush,
    input  logic                    victim_dirty,
    output logic                    busy,
    output logic                    done,
    output logic                    rewrite_tag,
    output logic                    line_rd_en,
    input  logic [DATA_WIDTH-1:0]   line_rd_data,
    output logic                    line_wr_en,
    output logic [CHANNEL_SIZE-1:0] line_channel,
    output logic [WORD_SIZE-1:0]    line_word,
    output logic [DATA_WIDTH-1:0]   line_wr_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    import cache_pkg::*;

    state_e                  state_q, state_d;
    logic [WORD_SIZE-1:0]    word_q, word_d;
    logic [TAG_SIZE-1:0]     tag_q, tag_d;
    logic [TAG_SIZE-1:0]     victim_tag_q, victim_tag_d;
    logic [INDEX_SIZE-1:0]   index_q, index_d;
    logic [CHANNEL_SIZE-1:0] channel_q, channel_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    cap_q, cap_d;

    logic                    flush_needed;
    logic                    last_word;
    logic                    xfer_valid;
    logic                    xfer_we;
    logic                    xfer_done;
    logic [ADDR_SIZE-1:0]    xfer_addr;

    assign flush_needed = need_use_fifo & victim_dirty;
    assign last_word    = &word_q;

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            tag_q        <= '0;
            victim_tag_q <= '0;
            index_q      <= '0;
            channel_q    <= '0;
            data_q       <= '0;
            cap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            tag_q        <= tag_d;
            victim_tag_q <= victim_tag_d;
            index_q      <= index_d;
            channel_q    <= channel_d;
            data_q       <= data_d;
            cap_q        <= cap_d;
        end
    end

    // The victim word arrives one cycle after the line read, so the first FLUSH_WR
    // cycle only captures it and the write request starts on the following cycle.
    assign xfer_valid = (state_q == ST_FILL_RD) | ((state_q == ST_FLUSH_WR) & ~cap_q);
    assign xfer_we    = (state_q == ST_FLUSH_WR);
    assign xfer_addr  = xfer_we ? {victim_tag_q, index_q, word_q} : {tag_q, index_q, word_q};

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        tag_d        = tag_q;
        victim_tag_d = victim_tag_q;
        index_d      = index_q;
        channel_d    = channel_q;
        data_d       = data_q;
        cap_d        = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        rewrite_tag  = 1'b0;
        line_rd_en   = 1'b0;
        line_wr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (miss_req) begin
                    tag_d        = miss_tag;
                    index_d      = miss_index;
                    channel_d    = fifo_channel;
                    victim_tag_d = fifo_tag_for_flush;
                    word_d       = '0;
                    state_d      = flush_needed ? ST_FLUSH_RD : ST_FILL_RD;
                end
            end
            ST_FLUSH_RD: begin
                line_rd_en = 1'b1;
                cap_d      = 1'b1;
                state_d    = ST_FLUSH_WR;
            end
            ST_FLUSH_WR: begin
                if (cap_q) begin
                    data_d = line_rd_data;
                end else if (xfer_done) begin
                    word_d  = word_q + 1'b1;
                    state_d = last_word ? ST_FILL_RD : ST_FLUSH_RD;
                end
            end
            ST_FILL_RD: begin
                if (xfer_done) begin
                    data_d  = mem_rdata;
                    state_d = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                line_wr_en = 1'b1;
                word_d     = word_q + 1'b1;
                state_d    = last_word ? ST_COMMIT : ST_FILL_RD;
            end
            ST_COMMIT: begin
                rewrite_tag = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign line_channel = channel_q;
    assign line_word    = word_q;
    assign line_wr_data = data_q;

    cache_mem_port #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_port (
        .clk          (clk),
        .not_reset    (not_reset),
        .xfer_valid_i (xfer_valid),
        .xfer_we_i    (xfer_we),
        .xfer_addr_i  (xfer_addr),
        .xfer_wdata_i (data_q),
        .xfer_done_o  (xfer_done),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack)
    );

endmodule
